gat_feat_reader: RTL

Readout engine on the feature side of `gat_top`: after a GAT layer completes, walks the new-feature BRAM read port (`feat_bram_addrb` / `feat_bram_dout`) from address 0 to the last feature word. It emits every word in order on an AXI-Stream master with full backpressure support. It sits between `gat_top` and the host/DMA path and replaces bench-side polling of the feature BRAM.

---
 rtl/gat_feat_reader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/gat_feat_reader.sv
// gat_feat_reader
// ---------------
// Streams the feature BRAM of gat_top out over AXI-Stream after a GAT layer
// finishes. A rising edge on gat_ready while idle starts one readout. The
// readout walks addresses 0..total-1, where total = NUM_SUBGRAPHS * F and F
// depends on gat_layer. Words are emitted in address order. Full
// backpressure is supported through a 2-entry output buffer with credit-based
// read issue.
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   gat_ready          : layer-complete level; a rising edge starts a readout
//   gat_layer          : 0 -> NUM_FEATURE_OUT, 1 -> NUM_FEATURE_FINAL features/node
//   feat_bram_enb      : BRAM port-B read enable (one read per asserted cycle)
//   feat_bram_addrb    : BRAM port-B address
//   feat_bram_dout     : BRAM read data, valid the cycle after the enb edge
//   m_axis_*           : AXI-Stream master (tuser = feature 0 of a node,
//                        tlast = final word of the layer)
//   rd_busy            : readout in progress (READ or DRAIN)
//   rd_done            : one-cycle pulse after the tlast handshake
//
// Handshake: a word transfers on a rising edge where tvalid and tready are
// both high. Once tvalid is high, tdata/tuser/tlast hold until that transfer.
// tvalid is a pure function of registered buffer occupancy and never looks at
// tready.
module gat_feat_reader #(
  parameter int DATA_WIDTH         = 8,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NUM_FEATURE_FINAL  = 7,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gat_ready,
  input  logic                          gat_layer,
  output logic                          feat_bram_enb,
  output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
  input  logic [DATA_WIDTH-1:0]         feat_bram_dout,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          rd_busy,
  output logic                          rd_done
);

  localparam int AW    = NEW_FEATURE_ADDR_W;
  localparam int F_MAX = (NUM_FEATURE_OUT > NUM_FEATURE_FINAL) ? NUM_FEATURE_OUT
                                                               : NUM_FEATURE_FINAL;
  localparam int FW    = (F_MAX > 1) ? $clog2(F_MAX) : 1;

  // Last address and last feature index for each layer. Storing total-1
  // rather than total keeps the compare inside the address width even when
  // the product is an exact power of two.
  localparam logic [AW-1:0] LAST_ADDR_L1 = AW'(NUM_SUBGRAPHS * NUM_FEATURE_OUT - 1);
  localparam logic [AW-1:0] LAST_ADDR_L2 = AW'(NUM_SUBGRAPHS * NUM_FEATURE_FINAL - 1);
  localparam logic [FW-1:0] LAST_FEAT_L1 = FW'(NUM_FEATURE_OUT - 1);
  localparam logic [FW-1:0] LAST_FEAT_L2 = FW'(NUM_FEATURE_FINAL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Start detection
  logic gat_ready_q;
  logic start;

  // Readout context latched on start
  logic [AW-1:0] last_addr;
  logic [FW-1:0] feat_last;

  // Issue side
  logic [AW-1:0] rd_addr;
  logic [FW-1:0] feat_idx;
  logic [AW-1:0] addr_q;
  logic          inflight;
  logic          pend_user;
  logic          pend_last;

  // 2-entry output buffer
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic                  buf_user [2];
  logic                  buf_last [2];
  logic                  head;
  logic [1:0]            count;
  logic                  tail;

  logic       pop;
  logic [2:0] occ;
  logic       issue;
  logic       last_issue;

  assign start = gat_ready & ~gat_ready_q;
  assign pop   = (count != 2'd0) & m_axis_tready;
  // Occupancy the buffer will have once this cycle's pop and the read in
  // flight have both settled; a new read is only allowed if it will fit.
  // pop implies count >= 1, so this subtraction never underflows.
  assign occ        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == READ) && (occ < 3'd2);
  assign last_issue = issue && (rd_addr == last_addr);
  assign tail       = head ^ count[0];

  // Next-state and status outputs
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    if (last_issue) state_next = DRAIN;
      DRAIN:   if (pop && buf_last[head]) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rd_busy = (state == READ) || (state == DRAIN);
  assign rd_done = (state == DONE);

  assign feat_bram_enb   = issue;
  assign feat_bram_addrb = issue ? rd_addr : addr_q;

  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = buf_data[head];
  assign m_axis_tuser  = buf_user[head];
  assign m_axis_tlast  = buf_last[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      // Resetting to 1 means a gat_ready already high at release is not
      // mistaken for a rising edge; it must drop and rise again.
      gat_ready_q <= 1'b1;
      last_addr   <= '0;
      feat_last   <= '0;
      rd_addr     <= '0;
      feat_idx    <= '0;
      addr_q      <= '0;
      inflight    <= 1'b0;
      pend_user   <= 1'b0;
      pend_last   <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_user[0] <= 1'b0;
      buf_user[1] <= 1'b0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
      head        <= 1'b0;
      count       <= 2'd0;
    end else begin
      state       <= state_next;
      gat_ready_q <= gat_ready;

      if (state == IDLE && start) begin
        last_addr <= gat_layer ? LAST_ADDR_L2 : LAST_ADDR_L1;
        feat_last <= gat_layer ? LAST_FEAT_L2 : LAST_FEAT_L1;
        rd_addr   <= '0;
        feat_idx  <= '0;
      end

      inflight <= issue;
      if (issue) begin
        addr_q    <= rd_addr;
        pend_user <= (feat_idx == '0);
        pend_last <= (rd_addr == last_addr);
        // Hold at the last address so the counter never wraps.
        if (!last_issue) rd_addr <= rd_addr + 1'b1;
        feat_idx <= (feat_idx == feat_last) ? '0 : feat_idx + 1'b1;
      end

      // Capture is unconditional one cycle after issue; the credit check
      // at issue time guarantees the tail slot is free.
      if (inflight) begin
        buf_data[tail] <= feat_bram_dout;
        buf_user[tail] <= pend_user;
        buf_last[tail] <= pend_last;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule
